// File: rtl/hdb3_decoder.sv
// rtl/hdb3_decoder.sv - HDB3 line decoder; optional error counter under HDB3_DEC_ERRCNT_EN
module hdb3_decoder
`ifdef HDB3_DEC_ERRCNT_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] datain,
  output logic       dataout,
  output logic       dataout_valid,
  output logic       code_err
`ifdef HDB3_DEC_ERRCNT_EN
  ,
  input  logic             err_cnt_clr,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam logic [2:0] SYM_ZERO = 3'b000;
  localparam logic [2:0] SYM_POS  = 3'b001;
  localparam logic [2:0] SYM_NEG  = 3'b010;

  // polarity history, zero-run tracking and the 4-deep recovery pipeline
  logic       last_pol;   // 1 = last mark was positive
  logic       mark_seen;
  logic       last_vpol;  // 1 = last violation was positive
  logic       v_seen;
  logic [2:0] zero_run;   // saturates at 4
  logic [3:0] sr;         // sr[0] newest, sr[3] drives dataout
  logic [2:0] fill;       // saturates at 4

  logic is_pos;
  logic is_neg;
  logic is_zero;
  logic is_mark;
  logic is_illegal;
  logic viol;
  logic zero_err;
  logic vpol_err;
  logic err_next;

  // symbol classification and error causes for the symbol being sampled
  always_comb begin
    is_pos     = (datain == SYM_POS);
    is_neg     = (datain == SYM_NEG);
    is_zero    = (datain == SYM_ZERO);
    is_mark    = is_pos | is_neg;
    is_illegal = ~(is_mark | is_zero);
    viol       = is_mark & mark_seen & (is_pos == last_pol);
    zero_err   = is_zero & (zero_run >= 3'd3);
    vpol_err   = viol & v_seen & (is_pos == last_vpol);
    err_next   = is_illegal | zero_err | vpol_err;
  end

  // main state update: shift marks in, wipe B00V/000V on a violation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_pol  <= 1'b0;
      mark_seen <= 1'b0;
      last_vpol <= 1'b0;
      v_seen    <= 1'b0;
      zero_run  <= 3'd0;
      sr        <= 4'b0000;
      fill      <= 3'd0;
      code_err  <= 1'b0;
    end else begin
      code_err <= err_next;

      // the V and the three positions before it are all substitution bits
      if (viol) begin
        sr <= 4'b0000;
      end else begin
        sr <= {sr[2:0], is_mark};
      end

      if (is_mark) begin
        last_pol  <= is_pos;
        mark_seen <= 1'b1;
      end

      if (viol) begin
        last_vpol <= is_pos;
        v_seen    <= 1'b1;
      end

      if (is_zero) begin
        if (zero_run != 3'd4) begin
          zero_run <= zero_run + 3'd1;
        end
      end else begin
        zero_run <= 3'd0;
      end

      if (fill != 3'd4) begin
        fill <= fill + 3'd1;
      end
    end
  end

  assign dataout       = sr[3];
  assign dataout_valid = (fill == 3'd4);

`ifdef HDB3_DEC_ERRCNT_EN
  // saturating error counter; clear has priority over a coincident error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (err_next && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// tb/tb_hdb3_decoder.sv - self-checking bench for hdb3_decoder
module tb_hdb3_decoder;

  localparam logic [2:0] P = 3'b001;
  localparam logic [2:0] N = 3'b010;
  localparam logic [2:0] Z = 3'b000;
  localparam logic [2:0] X = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] datain;
  logic       dataout;
  logic       dataout_valid;
  logic       code_err;
  logic       err_cnt_clr;
`ifdef HDB3_DEC_ERRCNT_EN
  logic [1:0] err_cnt;
`endif

  always #5 clk = ~clk;

`ifdef HDB3_DEC_ERRCNT_EN
  hdb3_decoder #(.CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .datain(datain),
    .dataout(dataout), .dataout_valid(dataout_valid), .code_err(code_err),
    .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt)
  );
`else
  hdb3_decoder dut (
    .clk(clk), .reset_n(reset_n), .datain(datain),
    .dataout(dataout), .dataout_valid(dataout_valid), .code_err(code_err)
  );
`endif

  int checks = 0;
  int errors = 0;

  // reference model: decoded history indexed by symbol position since reset
  bit hist[$];
  int m_last_pol;
  int m_last_vpol;
  int m_zrun;
  bit m_err;
  int m_cnt;

  function automatic void model_reset();
    hist.delete();
    m_last_pol  = 0;
    m_last_vpol = 0;
    m_zrun      = 0;
    m_err       = 0;
    m_cnt       = 0;
  endfunction

  function automatic void model_apply(input logic [2:0] s, input logic clr);
    int p;
    int j;
    bit err;
    p   = (s == P) ? 1 : (s == N) ? -1 : 0;
    err = 0;
    if (s == Z) begin
      m_zrun++;
      hist.push_back(1'b0);
      if (m_zrun >= 4) err = 1;
    end else if (p == 0) begin
      m_zrun = 0;
      hist.push_back(1'b0);
      err = 1;
    end else begin
      m_zrun = 0;
      if (p == m_last_pol) begin
        hist.push_back(1'b0);
        j = hist.size() - 1;
        for (int i = j - 3; i <= j; i++)
          if (i >= 0) hist[i] = 1'b0;
        if (p == m_last_vpol) err = 1;
        m_last_vpol = p;
      end else begin
        hist.push_back(1'b1);
      end
      m_last_pol = p;
    end
    m_err = err;
    if (clr) m_cnt = 0;
    else if (err && m_cnt < 3) m_cnt++;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    int j;
    int eo;
    int ev;
    j  = hist.size() - 1;
    ev = (j >= 3) ? 1 : 0;
    eo = (j >= 3) ? int'(hist[j-3]) : 0;
    check("model dataout", int'(dataout), eo);
    check("model valid", int'(dataout_valid), ev);
    check("model code_err", int'(code_err), int'(m_err));
`ifdef HDB3_DEC_ERRCNT_EN
    check("model err_cnt", int'(err_cnt), m_cnt);
`endif
  endtask

  task automatic tick(input logic [2:0] sym, input logic clr);
    datain      = sym;
    err_cnt_clr = clr;
    @(posedge clk);
    #1;
    model_apply(sym, clr);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] sym;
    logic       out;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t tbl[34];

  initial begin
    tbl[0]  = '{P, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{Z, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{N, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{Z, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{P, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{Z, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{Z, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{P, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{N, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{N, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{P, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{P, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{P, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[24] = '{X, 1'b0, 1'b1, 1'b1};
    tbl[25] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[26] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[28] = '{Z, 1'b0, 1'b1, 1'b1};
    tbl[29] = '{Z, 1'b0, 1'b1, 1'b1};
    tbl[30] = '{N, 1'b0, 1'b1, 1'b0};
    tbl[31] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[32] = '{Z, 1'b0, 1'b1, 1'b0};
    tbl[33] = '{Z, 1'b1, 1'b1, 1'b0};

    reset_n     = 1'b0;
    datain      = Z;
    err_cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset dataout", int'(dataout), 0);
    check("reset valid", int'(dataout_valid), 0);
    check("reset code_err", int'(code_err), 0);
`ifdef HDB3_DEC_ERRCNT_EN
    check("reset err_cnt", int'(err_cnt), 0);
`endif
    reset_n = 1'b1;

    // directed table: alternating marks, 000V, B00V, repeated V polarity, illegal, long zeros
    for (int i = 0; i < 34; i++) begin
      tick(tbl[i].sym, 1'b0);
      check($sformatf("tbl[%0d] dataout", i), int'(dataout), int'(tbl[i].out));
      check($sformatf("tbl[%0d] valid", i), int'(dataout_valid), int'(tbl[i].valid));
      check($sformatf("tbl[%0d] code_err", i), int'(code_err), int'(tbl[i].err));
      check_model();
    end

    // clear coincident with an error, then saturate the 2-bit counter
    tick(X, 1'b1);
    check("clr+err code_err", int'(code_err), 1);
`ifdef HDB3_DEC_ERRCNT_EN
    check("clr+err err_cnt", int'(err_cnt), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick(X, 1'b0);
      check("illegal burst code_err", int'(code_err), 1);
      check_model();
    end
`ifdef HDB3_DEC_ERRCNT_EN
    check("saturated err_cnt", int'(err_cnt), 3);
`endif

    // asynchronous reset mid-cycle clears outputs without a clock edge
    check("pre-reset valid", int'(dataout_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async dataout", int'(dataout), 0);
    check("async valid", int'(dataout_valid), 0);
    check("async code_err", int'(code_err), 0);
`ifdef HDB3_DEC_ERRCNT_EN
    check("async err_cnt", int'(err_cnt), 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // refill after reset: valid only after the 4th edge
    for (int i = 0; i < 4; i++) begin
      tick(P, 1'b0);
      check("refill valid", int'(dataout_valid), (i >= 3) ? 1 : 0);
      check_model();
    end

    // randomized stream against the model with occasional resets and clears
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [2:0] s;
      r = $urandom_range(0, 15);
      if (r < 8) s = Z;
      else if (r < 11) s = P;
      else if (r < 14) s = N;
      else if (r == 14) s = 3'($urandom_range(3, 7));
      else s = Z;
      tick(s, ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      check_model();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
